// File: rtl/bram_pattern_sequencer.sv
// bram_pattern_sequencer
//   Writes a deterministic address-derived pattern into a block RAM and then
//   reads every location back, counting mismatches. One run is a full write
//   sweep immediately followed by a full read sweep of the same addresses.
//
//   Pattern: P(x) = v | (v << 20) | 0x55000 with v = x + DATA_OFFSET,
//   evaluated at 32 bits and truncated to DATA_WIDTH bits.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   start          begin a run (accepted only in IDLE or DONE)
//   busy           run in progress (WRITE, READ, DRAIN)
//   done           run finished; held until restart or reset
//   pass           done with zero mismatches
//   err_cnt        mismatch count, saturating at 0xFFFF
//   first_err_addr address of the first mismatch of the run (0 if none)
//   wce/wa/wd      registered BRAM write-port drive
//   rce/ra         registered BRAM read-port drive
//   rq             BRAM read data, one cycle after each rce-high cycle
//   dbg_state      current FSM state (IDLE=0, WRITE=1, READ=2, DRAIN=3, DONE=4)
module bram_pattern_sequencer #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 18,
  parameter int ADDR_START  = 0,
  parameter int ADDR_COUNT  = 512,
  parameter int DATA_OFFSET = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  wce,
  output logic [ADDR_WIDTH-1:0] wa,
  output logic [DATA_WIDTH-1:0] wd,
  output logic                  rce,
  output logic [ADDR_WIDTH-1:0] ra,
  input  logic [DATA_WIDTH-1:0] rq,
  output logic [2:0]            dbg_state
);

  // Counter is one bit wider than the address so a full-depth sweep
  // (ADDR_COUNT == 2^ADDR_WIDTH) can be counted.
  localparam int                  CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]    LAST  = CNT_W'(ADDR_COUNT);
  localparam logic [ADDR_WIDTH-1:0] A0  = ADDR_WIDTH'(ADDR_START);
  localparam logic [ADDR_WIDTH-1:0] A1  = ADDR_WIDTH'(1);
  localparam logic [CNT_W-1:0]    C1    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] x);
    logic [31:0] v;
    logic [35:0] p;
    v = 32'(x) + 32'(DATA_OFFSET);
    p = 36'(v | (v << 20) | 32'h0005_5000);
    return DATA_WIDTH'(p);
  endfunction

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;     // next address to issue
  logic [CNT_W-1:0]        cnt_q, cnt_d;       // accesses issued in this sweep
  logic                    wce_q, wce_d;
  logic [ADDR_WIDTH-1:0]   wa_q, wa_d;
  logic [DATA_WIDTH-1:0]   wd_q, wd_d;
  logic                    rce_q, rce_d;
  logic [ADDR_WIDTH-1:0]   ra_q, ra_d;
  logic                    cmp_vld_q, cmp_vld_d;
  logic [DATA_WIDTH-1:0]   cmp_exp_q, cmp_exp_d;
  logic [ADDR_WIDTH-1:0]   cmp_addr_q, cmp_addr_d;
  logic [15:0]             err_q, err_d;
  logic [ADDR_WIDTH-1:0]   first_q, first_d;
  logic                    done_q, done_d;
  logic                    mismatch;

  // Read-data timing: rq is valid exactly in the cycle after an rce-high
  // cycle. cmp_vld/cmp_exp/cmp_addr carry that access forward one cycle so
  // they line up with its returning rq; there is no back-pressure.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wce_d      = 1'b0;
    wa_d       = wa_q;
    wd_d       = wd_q;
    rce_d      = 1'b0;
    ra_d       = ra_q;
    err_d      = err_q;
    first_d    = first_q;
    done_d     = done_q;
    cmp_vld_d  = rce_q;
    cmp_exp_d  = pattern(ra_q);
    cmp_addr_d = ra_q;

    // Case inequality so X/Z on rq counts as a mismatch in simulation.
    mismatch = cmp_vld_q && (rq !== cmp_exp_q);
    if (mismatch) begin
      if (err_q == 16'd0) first_d = cmp_addr_q;
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WRITE;
          wce_d   = 1'b1;
          wa_d    = A0;
          wd_d    = pattern(A0);
          addr_d  = A0 + A1;
          cnt_d   = C1;
          err_d   = 16'd0;
          first_d = '0;
          done_d  = 1'b0;
        end
      end
      S_WRITE: begin
        if (cnt_q == LAST) begin
          // Last write is on the bus now; first read goes out next cycle.
          state_d = S_READ;
          rce_d   = 1'b1;
          ra_d    = A0;
          addr_d  = A0 + A1;
          cnt_d   = C1;
        end else begin
          wce_d  = 1'b1;
          wa_d   = addr_q;
          wd_d   = pattern(addr_q);
          addr_d = addr_q + A1;
          cnt_d  = cnt_q + C1;
        end
      end
      S_READ: begin
        if (cnt_q == LAST) begin
          state_d = S_DRAIN;
        end else begin
          rce_d  = 1'b1;
          ra_d   = addr_q;
          addr_d = addr_q + A1;
          cnt_d  = cnt_q + C1;
        end
      end
      S_DRAIN: begin
        // Final compare resolves this cycle; results settle with done.
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      wce_q      <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      rce_q      <= 1'b0;
      ra_q       <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_exp_q  <= '0;
      cmp_addr_q <= '0;
      err_q      <= '0;
      first_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      wce_q      <= wce_d;
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      rce_q      <= rce_d;
      ra_q       <= ra_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_exp_q  <= cmp_exp_d;
      cmp_addr_q <= cmp_addr_d;
      err_q      <= err_d;
      first_q    <= first_d;
      done_q     <= done_d;
    end
  end

  assign busy           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done           = done_q;
  assign pass           = done_q && (err_q == 16'd0);
  assign err_cnt        = err_q;
  assign first_err_addr = first_q;
  assign wce            = wce_q;
  assign wa             = wa_q;
  assign wd             = wd_q;
  assign rce            = rce_q;
  assign ra             = ra_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_bram_pattern_sequencer.sv
// Two sequencers share clk/rst/start: instance A sweeps 0..7, instance B
// sweeps 14,15,0,1 (address wrap). Each has its own 1-cycle-latency RAM with
// per-address fault injection.
module tb_bram_pattern_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: start 0, count 8 ----------------
  logic        busy_a, done_a, pass_a, wce_a, rce_a;
  logic [15:0] err_a;
  logic [3:0]  first_a, wa_a, ra_a;
  logic [17:0] wd_a, rq_a;
  logic [2:0]  dbg_a;

  bram_pattern_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(18), .ADDR_START(0),
                           .ADDR_COUNT(8), .DATA_OFFSET(0)) u_a (
    .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_a), .first_err_addr(first_a), .wce(wce_a),
    .wa(wa_a), .wd(wd_a), .rce(rce_a), .ra(ra_a), .rq(rq_a), .dbg_state(dbg_a));

  // ---------------- DUT B: start 14, count 4 ----------------
  logic        busy_b, done_b, pass_b, wce_b, rce_b;
  logic [15:0] err_b;
  logic [3:0]  first_b, wa_b, ra_b;
  logic [17:0] wd_b, rq_b;
  logic [2:0]  dbg_b;

  bram_pattern_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(18), .ADDR_START(14),
                           .ADDR_COUNT(4), .DATA_OFFSET(0)) u_b (
    .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_cnt(err_b), .first_err_addr(first_b), .wce(wce_b),
    .wa(wa_b), .wd(wd_b), .rce(rce_b), .ra(ra_b), .rq(rq_b), .dbg_state(dbg_b));

  // ---------------- RAM models ----------------
  logic [15:0] fault_mask = 16'h0;   // faulted addresses return corrupted data
  logic        use_x = 1'b0;         // corrupted data is X instead of bit0 flip
  logic [17:0] mem_a [16];
  logic [17:0] mem_b [16];

  always @(posedge clk) begin
    if (wce_a) mem_a[wa_a] <= wd_a;
    if (rce_a) rq_a <= fault_mask[ra_a] ? (use_x ? 18'bx : mem_a[ra_a] ^ 18'h1) : mem_a[ra_a];
    if (wce_b) mem_b[wa_b] <= wd_b;
    if (rce_b) rq_b <= fault_mask[ra_b] ? (use_x ? 18'bx : mem_b[ra_b] ^ 18'h1) : mem_b[ra_b];
  end

  // ---------------- reference model ----------------
  // A run accepted at cycle t0 is described purely by elapsed cycles k:
  // writes k=1..N, reads N+1..2N, busy 1..2N+1, done from 2N+2; the read of
  // the j-th address is compared at k=N+2+j and counted from k=N+3+j.
  typedef struct {
    bit wce; bit rce; bit busy; bit done; bit pass; bit chk_wa; bit chk_ra;
    int wa; int wd; int ra; int err; int first;
  } exp_t;

  int          nn [2] = '{8, 4};
  int          ss [2] = '{0, 14};
  bit          has_run [2] = '{1'b0, 1'b0};
  int          t0 [2] = '{0, 0};
  logic [15:0] run_mask [2] = '{16'h0, 16'h0};
  int          cyc = 0;
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic int pat(input int x);
    longint v;
    v = x;
    return int'((v | (v << 20) | 64'h55000) % (64'd1 << 18));
  endfunction

  function automatic exp_t model(input int i, input int c);
    exp_t e;
    int k, n, s, adr;
    e = '{default: 0};
    if (!has_run[i]) begin
      e.chk_wa = 1'b1;
      e.chk_ra = 1'b1;
      return e;
    end
    k = c - t0[i];
    n = nn[i];
    s = ss[i];
    if (k >= 1 && k <= n) begin
      e.wce = 1'b1; e.chk_wa = 1'b1;
      e.wa = (s + k - 1) % 16;
      e.wd = pat(e.wa);
    end
    if (k >= n + 1 && k <= 2 * n) begin
      e.rce = 1'b1; e.chk_ra = 1'b1;
      e.ra = (s + k - n - 1) % 16;
    end
    e.busy = (k >= 1 && k <= 2 * n + 1);
    e.done = (k >= 2 * n + 2);
    for (int j = 0; j < n; j++) begin
      adr = (s + j) % 16;
      if (run_mask[i][adr] && k >= n + 3 + j) begin
        if (e.err == 0) e.first = adr;
        e.err++;
      end
    end
    e.pass = e.done && (e.err == 0);
    return e;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e = model(i, cyc);
      if (rst) has_run[i] <= 1'b0;
      else if (start && !e.busy) begin
        has_run[i]  <= 1'b1;
        t0[i]       <= cyc;
        run_mask[i] <= fault_mask;
      end
    end
    cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    exp_q.push_back(exp);
    n_checks++;
    if (act !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_inst(input string nm, input exp_t e, input logic w,
                            input logic [3:0] wa_v, input logic [17:0] wd_v,
                            input logic r, input logic [3:0] ra_v, input logic b,
                            input logic d, input logic p, input logic [15:0] ec,
                            input logic [3:0] fa);
    chk({nm, ".wce"}, 32'(w), 32'(e.wce));
    chk({nm, ".rce"}, 32'(r), 32'(e.rce));
    chk({nm, ".wce_and_rce"}, 32'(w & r), 32'd0);
    if (e.chk_wa) begin
      chk({nm, ".wa"}, 32'(wa_v), 32'(e.wa));
      chk({nm, ".wd"}, 32'(wd_v), 32'(e.wd));
    end
    if (e.chk_ra) chk({nm, ".ra"}, 32'(ra_v), 32'(e.ra));
    chk({nm, ".busy"}, 32'(b), 32'(e.busy));
    chk({nm, ".done"}, 32'(d), 32'(e.done));
    chk({nm, ".pass"}, 32'(p), 32'(e.pass));
    chk({nm, ".err_cnt"}, 32'(ec), 32'(e.err));
    chk({nm, ".first_err_addr"}, 32'(fa), 32'(e.first));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_inst("A", model(0, cyc), wce_a, wa_a, wd_a, rce_a, ra_a, busy_a, done_a, pass_a, err_a, first_a);
      check_inst("B", model(1, cyc), wce_b, wa_b, wd_b, rce_b, ra_b, busy_b, done_b, pass_b, err_b, first_b);
    end
  end

  // ---------------- driver ----------------
  // Pulses start (elapsed k=0), optionally re-pulses start at k=start_k and
  // rst at k=rst_k, and returns the elapsed cycle at which each done was
  // first seen (-1 if never, within a bounded window).
  task automatic run(input int start_k, input int rst_k, output int la, output int lb);
    @(negedge clk);
    start = 1'b1;
    la = -1;
    lb = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = (k == start_k);
      rst   = (k == rst_k);
      if (done_a && la < 0) la = k;
      if (done_b && lb < 0) lb = k;
      if (done_a && done_b && k > start_k && k > rst_k) break;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] mask;
    logic        xz;
    int          a_err;
    int          a_first;
    int          b_err;
    int          b_first;
  } vec_t;

  vec_t vecs [7];
  int   la, lb;

  initial begin
    vecs[0] = '{16'h0000, 1'b0, 0, 0, 0, 0};   // clean run
    vecs[1] = '{16'h0008, 1'b0, 1, 3, 0, 0};   // bit0 cleared at address 3
    vecs[2] = '{16'h0090, 1'b0, 2, 4, 0, 0};   // addresses 4 and 7
    vecs[3] = '{16'h00FF, 1'b0, 8, 0, 2, 0};   // all of A, B wraps into 0,1
    vecs[4] = '{16'hC000, 1'b1, 0, 0, 2, 14};  // X on B's 14,15
    vecs[5] = '{16'h0020, 1'b1, 1, 5, 0, 0};   // X on A's 5
    vecs[6] = '{16'h0000, 1'b0, 0, 0, 0, 0};   // clean restart after faults

    // power-up reset held for two edges
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset.busy_a", 32'(busy_a), 32'd0);
    chk("reset.done_a", 32'(done_a), 32'd0);
    chk("reset.err_a", 32'(err_a), 32'd0);
    chk("reset.wce_a", 32'(wce_a), 32'd0);
    chk("reset.rce_a", 32'(rce_a), 32'd0);

    // table-driven runs; each after the first restarts from DONE
    for (int v = 0; v < 7; v++) begin
      fault_mask = vecs[v].mask;
      use_x      = vecs[v].xz;
      run(0, 0, la, lb);
      chk($sformatf("vec%0d.done_lat_a", v), 32'(la), 32'd18);
      chk($sformatf("vec%0d.done_lat_b", v), 32'(lb), 32'd10);
      chk($sformatf("vec%0d.err_a", v), 32'(err_a), 32'(vecs[v].a_err));
      chk($sformatf("vec%0d.first_a", v), 32'(first_a), 32'(vecs[v].a_first));
      chk($sformatf("vec%0d.pass_a", v), 32'(pass_a), 32'(vecs[v].a_err == 0));
      chk($sformatf("vec%0d.err_b", v), 32'(err_b), 32'(vecs[v].b_err));
      chk($sformatf("vec%0d.first_b", v), 32'(first_b), 32'(vecs[v].b_first));
      chk($sformatf("vec%0d.pass_b", v), 32'(pass_b), 32'(vecs[v].b_err == 0));
    end

    // start pulsed while A is reading: A's timing must not move
    fault_mask = 16'h0;
    use_x      = 1'b0;
    run(11, 0, la, lb);
    chk("read_start.done_lat_a", 32'(la), 32'd18);
    chk("read_start.pass_a", 32'(pass_a), 32'd1);

    // reset during the 4th write cycle aborts both runs
    run(0, 4, la, lb);
    chk("midreset.never_done_a", 32'(la), 32'hFFFF_FFFF);
    chk("midreset.busy_a", 32'(busy_a), 32'd0);
    chk("midreset.rce_a", 32'(rce_a), 32'd0);
    chk("midreset.wce_a", 32'(wce_a), 32'd0);
    run(0, 0, la, lb);
    chk("post_reset.done_lat_a", 32'(la), 32'd18);
    chk("post_reset.pass_a", 32'(pass_a), 32'd1);
    chk("post_reset.pass_b", 32'(pass_b), 32'd1);

    // randomized runs: random faults, stray starts and occasional resets
    for (int r = 0; r < 12; r++) begin
      int sk, rk;
      fault_mask = 16'($urandom_range(0, 65535) & $urandom_range(0, 65535));
      use_x      = 1'($urandom_range(0, 1));
      sk = $urandom_range(0, 25);
      rk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
      run(sk, rk, la, lb);
      if (rk == 0) begin
        chk($sformatf("rand%0d.done_seen_a", r), 32'(la >= 0), 32'd1);
        chk($sformatf("rand%0d.done_seen_b", r), 32'(lb >= 0), 32'd1);
      end
      repeat (2) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
